// File: rtl/disp_scan_if.sv
// disp_scan_if: display scan bus (min/sec/adj/sel in; anode/digit/frame out)
interface disp_scan_if;
  logic [5:0] min;
  logic [5:0] sec;
  logic       adj;
  logic       sel;
  logic [3:0] anode;
  logic [3:0] digit;
  logic       frame;
  modport master (output min, sec, adj, sel, input anode, digit, frame);
  modport slave (input min, sec, adj, sel, output anode, digit, frame);
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit mm:ss display scanner; ports clk, rst, bus (min/sec/adj/sel in, anode/digit/frame out)
module disp_scan_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int BLINK_FRAMES = 128
) (
  input logic clk,
  input logic rst,
  disp_scan_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [PW-1:0] r_pcnt;
  logic [1:0]    r_slot;
  logic [5:0]    r_smin, r_ssec;
  logic [FW-1:0] r_fcnt;
  logic          r_bph, r_frame;
  logic [3:0]    r_anode, r_digit;
  logic          w_tick, w_wrap, w_blank, w_flast;
  logic [5:0]    w_val, w_cmin, w_csec;
  logic [3:0]    w_anode, w_digit;
  always_comb begin
    w_tick  = r_pcnt == PW'(SCAN_DIV - 1);
    w_wrap  = w_tick && r_slot == 2'd3;
    w_flast = r_fcnt == FW'(BLINK_FRAMES - 1);
    w_cmin  = bus.min > 6'd59 ? 6'd59 : bus.min;
    w_csec  = bus.sec > 6'd59 ? 6'd59 : bus.sec;
    w_val   = r_slot[1] ? r_ssec : r_smin;
    w_digit = 4'(r_slot[0] ? w_val % 6'd10 : w_val / 6'd10);
    w_blank = bus.adj && r_bph && (bus.sel == r_slot[1]);
    w_anode = w_blank ? 4'hf : ~(4'b1000 >> r_slot);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt  <= '0;
      r_slot  <= '0;
      r_smin  <= '0;
      r_ssec  <= '0;
      r_fcnt  <= '0;
      r_bph   <= 1'b0;
      r_anode <= 4'hf;
      r_digit <= '0;
      r_frame <= 1'b0;
    end else begin
      r_pcnt  <= w_tick ? '0 : r_pcnt + 1'b1;
      r_slot  <= w_tick ? r_slot + 1'b1 : r_slot;
      r_anode <= w_anode;
      r_digit <= w_digit;
      r_frame <= w_wrap;
      if (w_wrap) begin
        r_smin <= w_cmin;
        r_ssec <= w_csec;
        r_fcnt <= w_flast ? '0 : r_fcnt + 1'b1;
        r_bph  <= w_flast ? ~r_bph : r_bph;
      end
    end
  end
  assign bus.anode = r_anode;
  assign bus.digit = r_digit;
  assign bus.frame = r_frame;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scoreboard bench for disp_scan_ctrl against a cycle-count display model
module tb_disp_scan_ctrl;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FP = 4 * SD;
  typedef struct packed {logic [3:0] anode; logic [3:0] digit; logic frame;} exp_t;
  logic clk, rst;
  disp_scan_if u_if ();
  disp_scan_ctrl #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  int n = 0;
  int smin = 0, ssec = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int clampv(input logic [5:0] v);
    return v > 59 ? 59 : int'(v);
  endfunction
  task automatic step();
    exp_t e;
    int slot, f, val;
    bit bph, blank;
    if (rst) begin
      e = '{anode: 4'hf, digit: 4'd0, frame: 1'b0};
      n = 0;
      smin = 0;
      ssec = 0;
    end else begin
      slot = (n / SD) % 4;
      f = n / FP;
      bph = ((f / BF) % 2) == 1;
      val = slot < 2 ? smin : ssec;
      blank = u_if.adj && bph && (u_if.sel ? slot >= 2 : slot < 2);
      e.anode = blank ? 4'hf : 4'b1111 ^ (4'b1000 >> slot);
      e.digit = 4'((slot % 2 == 0) ? val / 10 : val % 10);
      e.frame = ((n + 1) % FP) == 0;
      if (e.frame) begin
        smin = clampv(u_if.min);
        ssec = clampv(u_if.sec);
      end
      n++;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (u_if.anode !== e.anode || u_if.digit !== e.digit || u_if.frame !== e.frame) begin
        miscompares++;
        $display("FAIL out t=%0t: anode=%b digit=%0d frame=%b, required anode=%b digit=%0d frame=%b",
                 $time, u_if.anode, u_if.digit, u_if.frame, e.anode, e.digit, e.frame);
      end
    end
  end
  initial begin
    int guard;
    rst = 1'b1;
    u_if.min = 6'd12;
    u_if.sec = 6'd34;
    u_if.adj = 1'b0;
    u_if.sel = 1'b0;
    run(3);
    rst = 1'b0;
    run(2 * FP);
    run(5);
    u_if.min = 6'd45;
    u_if.sec = 6'd7;
    run(2 * FP - 5);
    u_if.min = 6'd63;
    u_if.sec = 6'd60;
    run(2 * FP);
    u_if.min = 6'd23;
    u_if.sec = 6'd58;
    u_if.adj = 1'b1;
    u_if.sel = 1'b1;
    run(5 * FP + 6);
    u_if.sel = 1'b0;
    run(3 * FP);
    u_if.sel = 1'b1;
    guard = 0;
    while (!(((n / FP / BF) % 2) == 1 && ((n / SD) % 4) == 2 && (n % SD) == 1) && guard < 8 * FP) begin
      step();
      guard++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(3 * FP);
    u_if.adj = 1'b0;
    guard = 0;
    while (((n + 1) % FP) != 0 && guard < 2 * FP) begin
      step();
      guard++;
    end
    u_if.min = 6'd38;
    u_if.sec = 6'd19;
    step();
    u_if.min = 6'd1;
    u_if.sec = 6'd2;
    run(2 * FP);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) u_if.min = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) u_if.sec = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) u_if.adj = 1'($urandom);
      if ($urandom_range(0, 19) == 0) u_if.sel = 1'($urandom);
      rst = $urandom_range(0, 149) == 0;
      step();
    end
    rst = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 4) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
